// File: rtl/alu_sequencer.sv
// Command front end for SimpleALU: queues ALU commands, issues them one at a time,
// waits for Ready (with timeout) and returns captured results on a valid/ready channel.
module alu_sequencer #(
    parameter int                         INPUT_BIT_WIDTH = 8,
    parameter int                         INSTR_BIT_WIDTH = 5,
    parameter int                         FLAGS_COUNT     = 1,
    parameter int                         FIFO_DEPTH      = 4,
    parameter int                         TIMEOUT_CYCLES  = 64,
    parameter logic [INSTR_BIT_WIDTH-1:0] CODE_INSTR_NOP  = '0
) (
    input  logic                       Clk,
    input  logic                       Reset_n,
    // Command channel
    input  logic                       CmdValid,
    output logic                       CmdReady,
    input  logic [INSTR_BIT_WIDTH-1:0] CmdInstr,
    input  logic [INPUT_BIT_WIDTH-1:0] CmdA,
    input  logic [INPUT_BIT_WIDTH-1:0] CmdB,
    // ALU bus
    output logic [INSTR_BIT_WIDTH-1:0] AluInstruction,
    output logic [INPUT_BIT_WIDTH-1:0] AluInputA,
    output logic [INPUT_BIT_WIDTH-1:0] AluInputB,
    input  logic [INPUT_BIT_WIDTH-1:0] AluResultA,
    input  logic [INPUT_BIT_WIDTH-1:0] AluResultB,
    input  logic [FLAGS_COUNT-1:0]     AluFlags,
    input  logic                       AluReady,
    // Response channel
    output logic                       RspValid,
    input  logic                       RspReady,
    output logic [INPUT_BIT_WIDTH-1:0] RspResultA,
    output logic [INPUT_BIT_WIDTH-1:0] RspResultB,
    output logic [FLAGS_COUNT-1:0]     RspFlags,
    output logic                       RspTimeout,
    output logic                       Busy
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = $clog2(TIMEOUT_CYCLES);
    localparam int ENTRY_W = INSTR_BIT_WIDTH + 2 * INPUT_BIT_WIDTH;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic [ENTRY_W-1:0]         r_mem [FIFO_DEPTH];
    logic [PTR_W:0]             r_wr_ptr;
    logic [PTR_W:0]             r_rd_ptr;

    logic                       w_full;
    logic                       w_empty;
    logic                       w_push;
    logic                       w_pop;
    logic [ENTRY_W-1:0]         w_head;
    logic [INSTR_BIT_WIDTH-1:0] w_head_instr;
    logic [INPUT_BIT_WIDTH-1:0] w_head_a;
    logic [INPUT_BIT_WIDTH-1:0] w_head_b;

    state_t                     r_state;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                     (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);

    // A full FIFO refuses even when a pop happens in the same cycle.
    assign w_push  = CmdValid && !w_full;
    assign w_pop   = (r_state == S_IDLE) && !w_empty;

    assign w_head       = r_mem[r_rd_ptr[PTR_W-1:0]];
    assign w_head_instr = w_head[ENTRY_W-1 -: INSTR_BIT_WIDTH];
    assign w_head_a     = w_head[2*INPUT_BIT_WIDTH-1 -: INPUT_BIT_WIDTH];
    assign w_head_b     = w_head[INPUT_BIT_WIDTH-1:0];

    always_ff @(posedge Clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[PTR_W-1:0]] <= {CmdInstr, CmdA, CmdB};
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Issue / wait / respond FSM with registered outputs
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]           r_wait_cnt;
    logic [INSTR_BIT_WIDTH-1:0] r_alu_instr;
    logic [INPUT_BIT_WIDTH-1:0] r_alu_a;
    logic [INPUT_BIT_WIDTH-1:0] r_alu_b;
    logic                       r_rsp_valid;
    logic [INPUT_BIT_WIDTH-1:0] r_rsp_a;
    logic [INPUT_BIT_WIDTH-1:0] r_rsp_b;
    logic [FLAGS_COUNT-1:0]     r_rsp_flags;
    logic                       r_rsp_timeout;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state       <= S_IDLE;
            r_wait_cnt    <= '0;
            r_alu_instr   <= CODE_INSTR_NOP;
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_a       <= '0;
            r_rsp_b       <= '0;
            r_rsp_flags   <= '0;
            r_rsp_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        if (w_head_instr != CODE_INSTR_NOP) begin
                            r_alu_instr <= w_head_instr;
                            r_alu_a     <= w_head_a;
                            r_alu_b     <= w_head_b;
                            r_state     <= S_ISSUE;
                        end else begin
                            // NOP bypasses the ALU and answers with an all-zero response.
                            r_rsp_a       <= '0;
                            r_rsp_b       <= '0;
                            r_rsp_flags   <= '0;
                            r_rsp_timeout <= 1'b0;
                            r_rsp_valid   <= 1'b1;
                            r_state       <= S_RESP;
                        end
                    end
                end

                S_ISSUE: begin
                    r_wait_cnt <= '0;
                    r_state    <= S_WAIT;
                end

                S_WAIT: begin
                    if (AluReady) begin
                        r_rsp_a       <= AluResultA;
                        r_rsp_b       <= AluResultB;
                        r_rsp_flags   <= AluFlags;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_valid   <= 1'b1;
                        r_alu_instr   <= CODE_INSTR_NOP;
                        r_state       <= S_RESP;
                    end else if (r_wait_cnt == CNT_LAST) begin
                        r_rsp_a       <= '0;
                        r_rsp_b       <= '0;
                        r_rsp_flags   <= '0;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_valid   <= 1'b1;
                        r_alu_instr   <= CODE_INSTR_NOP;
                        r_state       <= S_RESP;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end
                end

                S_RESP: begin
                    if (RspReady) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign CmdReady       = !w_full;
    assign Busy           = (r_state != S_IDLE) || !w_empty;

    assign AluInstruction = r_alu_instr;
    assign AluInputA      = r_alu_a;
    assign AluInputB      = r_alu_b;

    assign RspValid       = r_rsp_valid;
    assign RspResultA     = r_rsp_a;
    assign RspResultB     = r_rsp_b;
    assign RspFlags       = r_rsp_flags;
    assign RspTimeout     = r_rsp_timeout;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: a behavioural ALU with programmable latency,
// expected responses queued at command acceptance and compared on each response handshake.
module tb_alu_sequencer;

    localparam int W  = 8;
    localparam int IW = 5;
    localparam int FC = 1;

    localparam logic [IW-1:0] OP_NOP = 5'b00000;
    localparam logic [IW-1:0] OP_ADD = 5'b00001;
    localparam logic [IW-1:0] OP_SUB = 5'b00010;
    localparam logic [IW-1:0] OP_MUL = 5'b00011;
    localparam logic [IW-1:0] OP_DIV = 5'b00100;

    typedef struct packed {
        logic [W-1:0]  ra;
        logic [W-1:0]  rb;
        logic [FC-1:0] fl;
        logic          to;
    } rsp_t;

    logic          Clk = 1'b0;
    logic          Reset_n;
    logic          CmdValid;
    logic          CmdReady;
    logic [IW-1:0] CmdInstr;
    logic [W-1:0]  CmdA;
    logic [W-1:0]  CmdB;
    logic [IW-1:0] AluInstruction;
    logic [W-1:0]  AluInputA;
    logic [W-1:0]  AluInputB;
    logic [W-1:0]  AluResultA;
    logic [W-1:0]  AluResultB;
    logic [FC-1:0] AluFlags;
    logic          AluReady;
    logic          RspValid;
    logic          RspReady;
    logic [W-1:0]  RspResultA;
    logic [W-1:0]  RspResultB;
    logic [FC-1:0] RspFlags;
    logic          RspTimeout;
    logic          Busy;

    alu_sequencer #(
        .INPUT_BIT_WIDTH(W),
        .INSTR_BIT_WIDTH(IW),
        .FLAGS_COUNT    (FC),
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (64),
        .CODE_INSTR_NOP (OP_NOP)
    ) dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .CmdValid      (CmdValid),
        .CmdReady      (CmdReady),
        .CmdInstr      (CmdInstr),
        .CmdA          (CmdA),
        .CmdB          (CmdB),
        .AluInstruction(AluInstruction),
        .AluInputA     (AluInputA),
        .AluInputB     (AluInputB),
        .AluResultA    (AluResultA),
        .AluResultB    (AluResultB),
        .AluFlags      (AluFlags),
        .AluReady      (AluReady),
        .RspValid      (RspValid),
        .RspReady      (RspReady),
        .RspResultA    (RspResultA),
        .RspResultB    (RspResultB),
        .RspFlags      (RspFlags),
        .RspTimeout    (RspTimeout),
        .Busy          (Busy)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_pass   = 0;
    int rsp_seen = 0;
    rsp_t sb_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference ALU behaviour; flag bit marks a zero ResultA.
    function automatic rsp_t ref_alu(input logic [IW-1:0] op, input logic [W-1:0] a,
                                     input logic [W-1:0] b);
        rsp_t r;
        logic [2*W-1:0] p;
        r = '0;
        p = (2*W)'(a) * (2*W)'(b);
        case (op)
            OP_ADD: r.ra = a + b;
            OP_SUB: r.ra = a - b;
            OP_MUL: begin r.ra = p[W-1:0]; r.rb = p[2*W-1:W]; end
            OP_DIV: begin r.ra = (b != 0) ? a / b : '0; r.rb = (b != 0) ? a % b : '0; end
            default: r = '0;
        endcase
        if (op != OP_NOP) r.fl = FC'(r.ra == 0);
        return r;
    endfunction

    // Behavioural ALU: Ready after alu_delay cycles of a held non-NOP instruction.
    int   alu_cnt   = 0;
    int   alu_delay = 0;
    bit   alu_stuck = 1'b0;
    rsp_t alu_r;

    always @(posedge Clk) alu_cnt <= (AluInstruction == OP_NOP) ? 0 : alu_cnt + 1;

    assign alu_r      = ref_alu(AluInstruction, AluInputA, AluInputB);
    assign AluResultA = alu_r.ra;
    assign AluResultB = alu_r.rb;
    assign AluFlags   = alu_r.fl;
    assign AluReady   = !alu_stuck && (AluInstruction != OP_NOP) && (alu_cnt >= alu_delay);

    // Response monitor: compare every handshake against the oldest expectation.
    always @(negedge Clk) begin
        if (Reset_n && RspValid && RspReady) begin
            rsp_t e;
            rsp_seen++;
            if (sb_q.size() == 0) begin
                check("rsp_unexpected", 32'(1), 32'(0));
            end else begin
                e = sb_q.pop_front();
                check("rsp_result_a", 32'(RspResultA), 32'(e.ra));
                check("rsp_result_b", 32'(RspResultB), 32'(e.rb));
                check("rsp_flags",    32'(RspFlags),   32'(e.fl));
                check("rsp_timeout",  32'(RspTimeout), 32'(e.to));
            end
        end
    end

    // Offer one command for up to max_cyc cycles; queue its expected response if taken.
    task automatic push_cmd(input logic [IW-1:0] op, input logic [W-1:0] a,
                            input logic [W-1:0] b, input int max_cyc, output bit ok);
        rsp_t e;
        ok       = 1'b0;
        CmdValid = 1'b1;
        CmdInstr = op;
        CmdA     = a;
        CmdB     = b;
        for (int i = 0; i < max_cyc && !ok; i++) begin
            @(negedge Clk);
            if (CmdReady) begin
                ok = 1'b1;
                if (alu_stuck && op != OP_NOP) begin
                    e    = '0;
                    e.to = 1'b1;
                end else begin
                    e = ref_alu(op, a, b);
                end
                sb_q.push_back(e);
            end
            @(posedge Clk); #1;
        end
        CmdValid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int cyc = 0;
        while ((Busy || RspValid || sb_q.size() != 0) && cyc < 300) begin
            @(posedge Clk); #1;
            cyc++;
        end
        check(tag, 32'(cyc < 300), 32'(1));
    endtask

    // Cycles from acceptance edge until RspValid is seen high.
    task automatic rsp_latency(output int cyc);
        cyc = 0;
        do begin
            @(posedge Clk); #1;
            cyc++;
        end while (!RspValid && cyc < 200);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit ok;
        int cyc;
        bit bad;
        int seen_before;

        Reset_n  = 1'b0;
        CmdValid = 1'b0;
        CmdInstr = '0;
        CmdA     = '0;
        CmdB     = '0;
        RspReady = 1'b1;
        #12;
        check("rst_alu_instr", 32'(AluInstruction), 32'(OP_NOP));
        check("rst_alu_a",     32'(AluInputA),      32'(0));
        check("rst_alu_b",     32'(AluInputB),      32'(0));
        check("rst_rsp_valid", 32'(RspValid),       32'(0));
        check("rst_rsp_a",     32'(RspResultA),     32'(0));
        check("rst_rsp_b",     32'(RspResultB),     32'(0));
        check("rst_rsp_flags", 32'(RspFlags),       32'(0));
        check("rst_rsp_to",    32'(RspTimeout),     32'(0));
        check("rst_busy",      32'(Busy),           32'(0));
        check("rst_cmd_ready", 32'(CmdReady),       32'(1));
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        @(posedge Clk); #1;

        // ADD with immediate Ready: bus after N+1, response after N+3.
        alu_delay = 0;
        push_cmd(OP_ADD, 8'd15, 8'd7, 4, ok);
        check("add_accept", 32'(ok), 32'(1));
        check("add_busy",   32'(Busy), 32'(1));
        @(posedge Clk); #1;
        check("add_alu_instr", 32'(AluInstruction), 32'(OP_ADD));
        check("add_alu_a",     32'(AluInputA),      32'(15));
        check("add_alu_b",     32'(AluInputB),      32'(7));
        @(posedge Clk); #1;
        check("add_rsp_early", 32'(RspValid), 32'(0));
        @(posedge Clk); #1;
        check("add_rsp_n3",    32'(RspValid),   32'(1));
        check("add_rsp_a",     32'(RspResultA), 32'(22));
        check("add_alu_nop",   32'(AluInstruction), 32'(OP_NOP));
        wait_idle("add_idle");

        // NOP bypass: response one edge after pop, ALU bus untouched.
        push_cmd(OP_NOP, 8'd5, 8'd9, 4, ok);
        check("nop_accept", 32'(ok), 32'(1));
        @(posedge Clk); #1;
        check("nop_rsp_n1",    32'(RspValid),       32'(1));
        check("nop_alu_instr", 32'(AluInstruction), 32'(OP_NOP));
        wait_idle("nop_idle");
        check("nop_alu_instr_after", 32'(AluInstruction), 32'(OP_NOP));

        // Multi-cycle DIV: 10 not-ready WAIT samples, operands held throughout.
        alu_delay = 11;
        push_cmd(OP_DIV, 8'd15, 8'd7, 4, ok);
        bad = 1'b0;
        cyc = 0;
        do begin
            @(posedge Clk); #1;
            cyc++;
            if (!RspValid && (AluInstruction != OP_DIV || AluInputA != 8'd15 || AluInputB != 8'd7))
                bad = 1'b1;
        end while (!RspValid && cyc < 200);
        check("div_latency",   32'(cyc), 32'(13));
        check("div_bus_stable", 32'(bad), 32'(0));
        check("div_ops_kept",  32'({AluInputA, AluInputB}), 32'({8'd15, 8'd7}));
        wait_idle("div_idle");
        alu_delay = 0;

        // Timeout: Ready stuck low, response after N+2+64 with RspTimeout set.
        alu_stuck = 1'b1;
        push_cmd(OP_MUL, 8'd3, 8'd4, 4, ok);
        rsp_latency(cyc);
        check("to_latency",   32'(cyc), 32'(66));
        check("to_alu_instr", 32'(AluInstruction), 32'(OP_NOP));
        wait_idle("to_idle");
        alu_stuck = 1'b0;

        // Back-pressure: 5 taken (1 in FSM, 4 queued), the 6th waits for the first pop.
        RspReady = 1'b0;
        push_cmd(OP_ADD, 8'd1,   8'd2,   1, ok); check("bp_acc1", 32'(ok), 32'(1));
        push_cmd(OP_SUB, 8'd9,   8'd4,   1, ok); check("bp_acc2", 32'(ok), 32'(1));
        push_cmd(OP_MUL, 8'd5,   8'd6,   1, ok); check("bp_acc3", 32'(ok), 32'(1));
        push_cmd(OP_DIV, 8'd20,  8'd3,   1, ok); check("bp_acc4", 32'(ok), 32'(1));
        push_cmd(OP_ADD, 8'd200, 8'd100, 1, ok); check("bp_acc5", 32'(ok), 32'(1));
        check("bp_full_ready", 32'(CmdReady), 32'(0));
        push_cmd(OP_SUB, 8'd3, 8'd3, 6, ok);
        check("bp_acc6_blocked", 32'(ok), 32'(0));
        check("bp_rsp_held",     32'(RspValid), 32'(1));
        check("bp_rsp_held_a",   32'(RspResultA), 32'(3));
        RspReady = 1'b1;
        push_cmd(OP_SUB, 8'd3, 8'd3, 10, ok);
        check("bp_acc6", 32'(ok), 32'(1));
        wait_idle("bp_idle");

        // Reset in WAIT with two commands queued: everything discarded.
        alu_stuck = 1'b1;
        push_cmd(OP_MUL, 8'd2, 8'd3, 4, ok);
        push_cmd(OP_ADD, 8'd4, 8'd4, 4, ok);
        push_cmd(OP_SUB, 8'd8, 8'd1, 4, ok);
        @(posedge Clk); #1;
        check("rw_busy_before", 32'(Busy), 32'(1));
        #2;
        Reset_n = 1'b0;
        #1;
        check("rw_alu_instr", 32'(AluInstruction), 32'(OP_NOP));
        check("rw_alu_a",     32'(AluInputA),      32'(0));
        check("rw_alu_b",     32'(AluInputB),      32'(0));
        check("rw_rsp_valid", 32'(RspValid),       32'(0));
        check("rw_rsp_to",    32'(RspTimeout),     32'(0));
        check("rw_busy",      32'(Busy),           32'(0));
        check("rw_cmd_ready", 32'(CmdReady),       32'(1));
        sb_q.delete();
        alu_stuck = 1'b0;
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        seen_before = rsp_seen;
        repeat (20) @(posedge Clk);
        #1;
        check("rw_no_stale", 32'(rsp_seen - seen_before), 32'(0));
        check("rw_idle_valid", 32'(RspValid), 32'(0));
        check("rw_idle_busy",  32'(Busy),     32'(0));
        check("rw_idle_ready", 32'(CmdReady), 32'(1));

        // Normal operation resumes after reset.
        push_cmd(OP_ADD, 8'd10, 8'd20, 4, ok);
        check("post_rst_accept", 32'(ok), 32'(1));
        wait_idle("post_rst_idle");
        check("sb_drained", 32'(sb_q.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
